// File: rtl/ram_dump_pkg.sv
// Shared definitions for the RAM dump transmitter.
// Contents:
//   state_t / St*           - top-level FSM state encoding
//   RAW_BYTES_PER_WORD      - UART frames per word in raw binary mode
//   HEX_BYTES_PER_WORD      - UART frames per word in ASCII hex mode (4 digits + CR + LF)
//   nibble_to_ascii()       - 4-bit value to uppercase ASCII hex digit
package ram_dump_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StRead  = 3'd1;
  localparam state_t StLatch = 3'd2;
  localparam state_t StSend  = 3'd3;
  localparam state_t StNext  = 3'd4;
  localparam state_t StDone  = 3'd5;

  localparam int unsigned RAW_BYTES_PER_WORD = 2;
  localparam int unsigned HEX_BYTES_PER_WORD = 6;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    // '0' is 0x30, 'A' is 0x41 = 0x37 + 10
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 UART serializer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   valid/ready - byte handshake; a byte is taken on a clock edge with both high
//   data        - byte to send, LSB first
//   frame_last  - high in the next-to-last cycle of the stop bit
//   tx          - serial output, idles high
// ready is also high in the last stop-bit cycle so a following byte starts with no gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       frame_last,
  output logic       tx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic            active_q;
  logic            tx_q;
  logic [8:0]      shift_q;  // remaining data bits plus the stop bit
  logic [3:0]      bits_q;   // bits still to shift out after the current one
  logic [CntW-1:0] cnt_q;

  logic last_cycle;

  always_comb begin
    last_cycle = active_q && (bits_q == 4'd0) && (cnt_q == '0);
    ready      = !active_q || last_cycle;
    frame_last = active_q && (bits_q == 4'd0) && (cnt_q == CntW'(1));
    tx         = tx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      shift_q  <= '1;
      bits_q   <= 4'd0;
      cnt_q    <= '0;
    end else if (valid && ready) begin
      active_q <= 1'b1;
      tx_q     <= 1'b0;
      shift_q  <= {1'b1, data};
      bits_q   <= 4'd9;
      cnt_q    <= CntMax;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (bits_q == 4'd0) begin
        active_q <= 1'b0;
      end else begin
        tx_q    <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
        bits_q  <= bits_q - 4'd1;
        cnt_q   <= CntMax;
      end
    end
  end

endmodule

// File: rtl/ram_dump_tx.sv
// Dumps a contiguous address range of a 1024x16 block RAM out of the UART TX pin.
// Each word is read through the RAM's synchronous read port and sent as 8N1 frames.
// Build option: define RAM_DUMP_HEX_EN to send each word as 4 ASCII hex digits + CR LF;
// otherwise the word is sent as two raw bytes, high byte first.
// Ports:
//   clk, rst             - clock (also the RAM rdclk), synchronous active-high reset
//   start                - one-cycle dump request, ignored while busy
//   start_addr, end_addr - inclusive range, sampled when start is accepted; wraps past the top
//   rden, rdaddr, rddata - RAM read port, data valid one cycle after rden
//   tx                   - UART serial output
//   busy                 - dump in progress
//   done                 - one-cycle pulse when the dump completes
module ram_dump_tx
  import ram_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              rden,
  output logic [ADDR_W-1:0] rdaddr,
  input  logic [DATA_W-1:0] rddata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

`ifdef RAM_DUMP_HEX_EN
  localparam int unsigned BytesPerWord = HEX_BYTES_PER_WORD;
`else
  localparam int unsigned BytesPerWord = RAW_BYTES_PER_WORD;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [2:0]        idx_q, idx_d;  // frame index within the current word

  logic       byte_valid;
  logic       byte_ready;
  logic       frame_last;
  logic [7:0] byte_data;

  always_comb begin
`ifdef RAM_DUMP_HEX_EN
    case (idx_q)
      3'd0:    byte_data = nibble_to_ascii(word_q[15:12]);
      3'd1:    byte_data = nibble_to_ascii(word_q[11:8]);
      3'd2:    byte_data = nibble_to_ascii(word_q[7:4]);
      3'd3:    byte_data = nibble_to_ascii(word_q[3:0]);
      3'd4:    byte_data = 8'h0D;
      default: byte_data = 8'h0A;
    endcase
`else
    byte_data = (idx_q == 3'd0) ? word_q[15:8] : word_q[7:0];
`endif
    byte_valid = (state_q == StSend) && (idx_q < 3'(BytesPerWord));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    word_d  = word_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = start_addr;
          last_d  = end_addr;
          state_d = StRead;
        end
      end
      StRead:  state_d = StLatch;
      StLatch: begin
        word_d  = rddata;
        idx_d   = 3'd0;
        state_d = StSend;
      end
      StSend: begin
        if (byte_valid && byte_ready) begin
          idx_d = idx_q + 3'd1;
        end else if (!byte_valid && frame_last) begin
          // Leave one cycle early so NEXT overlaps the final stop-bit cycle.
          state_d = StNext;
        end
      end
      StNext: begin
        if (addr_q == last_q) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      last_q  <= '0;
      word_q  <= '0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    rden   = (state_q == StRead);
    rdaddr = addr_q;
    busy   = (state_q != StIdle) && (state_q != StDone);
    done   = (state_q == StDone);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk        (clk),
    .rst        (rst),
    .valid      (byte_valid),
    .data       (byte_data),
    .ready      (byte_ready),
    .frame_last (frame_last),
    .tx         (tx)
  );

endmodule

// File: tb/tb_ram_dump_tx.sv
// Self-checking bench for ram_dump_tx: expected bytes and read addresses are queued when a
// dump is requested and popped by the UART decoder and read-port monitors.
module tb_ram_dump_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 10;
`ifdef RAM_DUMP_HEX_EN
  localparam int BPW = 6;
`else
  localparam int BPW = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          rden;
  logic [AW-1:0] rdaddr;
  logic [15:0]   rddata = '0;
  logic          tx;
  logic          busy;
  logic          done;

  logic [15:0] mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_bytes [$];
  int         exp_addrs [$];
  int         done_total = 0;
  int         busy_total = 0;
  logic       mon_drop = 1'b0;

  ram_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .DATA_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rden       (rden),
    .rdaddr     (rdaddr),
    .rddata     (rddata),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM read port
  always @(posedge clk) begin
    if (rden) rddata <= mem[rdaddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_word(input logic [15:0] w);
`ifdef RAM_DUMP_HEX_EN
    string hx = "0123456789ABCDEF";
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(hx[w[4*i +: 4]]);
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
`else
    exp_bytes.push_back(w[15:8]);
    exp_bytes.push_back(w[7:0]);
`endif
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) done_total <= done_total + 1;
    if (busy === 1'b1) busy_total <= busy_total + 1;
  end

  // Read-port monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rden === 1'b1) begin
        check_eq("rden_expected", 32'(exp_addrs.size() != 0), 32'd1);
        if (exp_addrs.size() != 0) check_eq("rdaddr", 32'(rdaddr), 32'(exp_addrs.pop_front()));
      end
    end
  end

  // UART decoder: sample each bit mid-period
  initial begin
    logic [7:0] b;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        if (mon_drop) begin
          mon_drop = 1'b0;
        end else begin
          check_eq("uart_byte_expected", 32'(exp_bytes.size() != 0), 32'd1);
          if (exp_bytes.size() != 0) check_eq("uart_byte", 32'(b), 32'(exp_bytes.pop_front()));
          check_eq("uart_stop", 32'(stop_bit), 32'd1);
        end
      end
    end
  end

  task automatic run_dump(input int sa, input int ea, input string tag);
    int a, nwords, d0, b0, budget;
    bit seen;
    a = sa;
    nwords = 0;
    forever begin
      exp_addrs.push_back(a);
      push_word(mem[a]);
      nwords++;
      if (a == ea) break;
      a = (a + 1) % 1024;
    end
    d0 = done_total;
    b0 = busy_total;
    budget = nwords * (3 + BPW * 10 * CPB) + 20;
    @(negedge clk);
    start = 1'b1;
    start_addr = AW'(sa);
    end_addr = AW'(ea);
    @(negedge clk);
    start = 1'b0;
    // range inputs are sampled only at acceptance
    start_addr = AW'(sa + 5);
    end_addr = AW'(sa + 5);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_total != d0) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    check_eq({tag, "_done_pulses"}, 32'(done_total - d0), 32'd1);
    check_eq({tag, "_busy_cycles"}, 32'(busy_total - b0), 32'(nwords * (3 + BPW * 10 * CPB)));
    check_eq({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    check_eq({tag, "_reads_left"}, 32'(exp_addrs.size()), 32'd0);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_tx_idle"}, 32'(tx), 32'd1);
    exp_bytes.delete();
    exp_addrs.delete();
  endtask

  initial begin
    int d0;
    bit seen;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    mem[1] = 16'hAAAA;
    mem[2] = 16'h5555;
    mem[3] = 16'hFFFF;
    mem[1023] = 16'hBEEF;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_rden", 32'(rden), 32'd0);
    check_eq("reset_rdaddr", 32'(rdaddr), 32'd0);

    run_dump(0, 0, "single");
    run_dump(1, 3, "range");
    run_dump(1023, 1, "wrap");

    // Extra start mid-dump is ignored; reset during the second data bit truncates the frame.
    exp_addrs.push_back(2);
    mon_drop = 1'b1;
    d0 = done_total;
    @(negedge clk);
    start = 1'b1;
    start_addr = AW'(2);
    end_addr = AW'(3);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    check_eq("rst_start_bit", 32'(seen), 32'd1);
    @(negedge clk);
    start = 1'b1;
    start_addr = AW'(0);
    end_addr = AW'(0);
    @(negedge clk);
    start = 1'b0;
    repeat (CPB + 3) @(negedge clk);
    check_eq("rst_busy_before", 32'(busy), 32'd1);
    check_eq("rst_addr_held", 32'(rdaddr), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rden", 32'(rden), 32'd0);
    check_eq("rst_rdaddr", 32'(rdaddr), 32'd0);
    check_eq("rst_reads_left", 32'(exp_addrs.size()), 32'd0);
    exp_addrs.delete();
    exp_bytes.delete();
    repeat (50) @(negedge clk);
    check_eq("rst_no_done", 32'(done_total - d0), 32'd0);
    check_eq("rst_tx_quiet", 32'(tx), 32'd1);
    check_eq("rst_frame_dropped", 32'(mon_drop), 32'd0);
    mon_drop = 1'b0;

    run_dump(0, 0, "post_rst");
    run_dump(1, 1, "word_a1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dump_tx.md
# ram_dump_tx

Reads a contiguous range of the 1024×16 block RAM through its synchronous read port and streams each word out on the UART TX pin, 8N1, high byte first. This is the read-out counterpart to the switch-driven RAM writer: the writer fills the RAM, and this block dumps the RAM to the host over the serial link. It replaces the `tx = rx` loopback in the RAM test top and connects directly to the RAM's `rdclk`/`rden`/`rdaddr`/`do` port.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal values ≥ 2.
- `ADDR_W`, 10: RAM address width.
- `DATA_W`, 16: RAM word width; fixed at 16 (two bytes per word).

Ports:
- `clk`  in  1  single clock for all logic; also drives the RAM `rdclk`.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`.
- `start_addr`  in  ADDR_W  first address; sampled when `start` is accepted.
- `end_addr`  in  ADDR_W  last address (inclusive); sampled when `start` is accepted.
- `rden`  out  1  RAM read enable.
- `rdaddr`  out  ADDR_W  RAM read address.
- `rddata`  in  DATA_W  RAM read data; valid one cycle after `rden`.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high from `start` acceptance until the dump completes.
- `done`  out  1  one-cycle pulse when the final stop bit ends.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `rden`=0, `rdaddr`=0, FSM=IDLE.
- States:
  - IDLE: `start`=1 latches the range, sets `rdaddr`=`start_addr` and `busy`=1, then goes to READ.
  - READ: `rden`=1 for exactly one cycle, then goes to LATCH.
  - LATCH: captures `rddata` into the word register, then goes to SEND.
  - SEND: shifts out the bytes of the word; after the last stop bit, goes to NEXT.
  - NEXT: if `rdaddr`==`end_addr`, goes to DONE; otherwise sets `rdaddr`=`rdaddr`+1 mod 2^ADDR_W and goes to READ.
  - DONE: `done`=1 and `busy`=0 in the same cycle, then returns to IDLE.
- Byte frame: start bit 0, data bits 0–7 LSB first, stop bit 1; each bit lasts `CLKS_PER_BIT` cycles.
- Raw mode sends byte `word[15:8]` then `word[7:0]` back to back, with no idle gap between them.
- Wrap-around: if `end_addr` < `start_addr`, the address counts up through 1023, wraps to 0, and continues to `end_addr`. `start_addr`==`end_addr` dumps exactly one word.
- `start` while `busy` has no effect. `start_addr`/`end_addr` changes after acceptance have no effect.
- `rdaddr` holds its value outside READ; `rden` is 0 in every state except READ.
- Reset mid-frame: state returns to IDLE on the next edge and `tx` goes to 1, even if a frame is cut short. The host tolerates a truncated byte.

## Timing
- `start` sampled at edge k: `busy`=1 and `rdaddr` valid after k; `rden`=1 during cycle k+1; data captured at k+2; `tx` falls (start bit) at edge k+3.
- Per word, raw mode: 2×10×`CLKS_PER_BIT` cycles of `tx`, plus 3 overhead cycles (NEXT, READ, LATCH) of `tx`=1 idle between words.
- `done` is high exactly one cycle, starting one cycle after the last stop bit completes.

## Configuration
- `RAM_DUMP_HEX_EN` defined: each word is sent as 4 ASCII uppercase hex characters, MSN first ("0"–"9", "A"–"F"), followed by CR (0x0D) and LF (0x0A), for 6 frames per word. Each frame is an 8N1 byte as above.
- `RAM_DUMP_HEX_EN` undefined: raw 2-byte binary per word, and no hex encoder logic is present.

## Structure
- Package `ram_dump_pkg` holds:
  - the FSM state enum;
  - `RAW_BYTES_PER_WORD`=2 and `HEX_BYTES_PER_WORD`=6;
  - the `nibble_to_ascii` function.
- Sub-module `uart_tx_byte` is a one-byte 8N1 serializer. It has a `valid`/`ready` input handshake, `CLKS_PER_BIT` as a parameter, and the same `clk`/`rst`. `ram_dump_tx` sequences bytes into it.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and RAM preloaded with 0x0001, 0xAAAA, 0x5555, 0xFFFF at addresses 0–3, with a one-cycle-latency RAM model.
- Single word: `start`, `start_addr`=0, `end_addr`=0 → `tx` decodes 0x00, 0x01; `done` pulses once; `busy` high for 3 + 80 cycles.
- Range: 1→3 → bytes AA AA 55 55 FF FF, in order; `rden` pulses exactly 3 times with `rdaddr` 1, 2, 3.
- Wrap: `start_addr`=1023, `end_addr`=1 → `rdaddr` sequence 1023, 0, 1; 6 bytes sent.
- `start` reasserted mid-dump, then reset during the second data bit → the extra `start` is ignored. After reset: `tx`=1, `busy`=0, no `done`; a new `start` begins a clean frame.
- `RAM_DUMP_HEX_EN` defined, address 1 → chars "AAAA\r\n" (41 41 41 41 0D 0A); address 0 → "0001\r\n".
